tdc_avg_accum: RTL and testbench

- Sits directly downstream of the 16-channel TDC multiply/sum stage.
- Consumes each 37-bit summed time code and its one-cycle valid strobe.
- Averages 2^k consecutive codes per block, with round-half-up, and tracks the per-block minimum and maximum.
- Presents {avg, min, max} on a valid/ready output register. An overrun flag reports any result lost because the consumer stalled.

---
 rtl/tdc_pkg.sv | 27 ++
 rtl/tdc_round_shift.sv | 38 +++
 rtl/tdc_avg_accum.sv | 187 ++++++++++++++++++
 tb/tb_tdc_avg_accum.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC averaging path.
//   TDC_SUM_W       width of the summed time code from the multiply/sum stage
//   TDC_LOG2_N_MAX  largest supported block-length exponent
//   tdc_state_e     averaging FSM states
//   tdc_result_t    one completed block result {avg, min, max}
//   clamp_k         limits a requested exponent to the supported range
package tdc_pkg;

    localparam int TDC_SUM_W      = 37;
    localparam int TDC_LOG2_N_MAX = 8;

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } tdc_state_e;

    typedef struct packed {
        logic [TDC_SUM_W-1:0] avg;
        logic [TDC_SUM_W-1:0] min;
        logic [TDC_SUM_W-1:0] max;
    } tdc_result_t;

    function automatic logic [3:0] clamp_k(input logic [3:0] req, input int max_k);
        return (int'(req) > max_k) ? 4'(max_k) : req;
    endfunction

endpackage

// File: rtl/tdc_round_shift.sv
// Combinational round-half-up right shift: avg = (acc + 2^(k-1)) >> k,
// or acc unchanged for k = 0. The rounding add is one bit wider than acc
// so it can never wrap.
//   acc  in  AW  value to be divided by 2^k
//   k    in  4   shift amount
//   avg  out W   rounded quotient (caller guarantees it fits in W bits)
module tdc_round_shift #(
    parameter int W  = 37,
    parameter int AW = 45
) (
    input  logic [AW-1:0] acc,
    input  logic [3:0]    k,
    output logic [W-1:0]  avg
);

    logic [AW:0] half;
    logic [AW:0] sum;
    logic [AW:0] shifted;

    // NOTE: every signal written in always_comb is given a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        half = '0;
        if (k != 4'd0) begin
            half = (AW+1)'(1) << (k - 4'd1);
        end
        sum     = {1'b0, acc} + half;
        shifted = sum >> k;
    end

    assign avg = shifted[W-1:0];

    // Upper quotient bits are always zero because a mean never exceeds
    // the largest input.
    logic unused_hi;
    assign unused_hi = ^shifted[AW:W];

endmodule

// File: rtl/tdc_avg_accum.sv
// Block averager behind the 16-channel TDC sum stage. Averages 2^k
// consecutive codes with round-half-up, tracks block min/max, and presents
// the result on a valid/ready register. Results that complete while the
// register is full and not being drained are dropped and counted.
//   clk        in   1   system clock
//   rst        in   1   asynchronous reset, active-low
//   in_data    in   W   summed time code
//   in_dval    in   1   single-cycle valid for in_data
//   en         in   1   averaging enable (level)
//   log2_n     in   4   block exponent k, sampled on IDLE->ACCUM only
//   clr        in   1   synchronous clear, same effect as reset
//   out_ready  in   1   consumer accepts the result
//   out_valid  out  1   result register holds an unconsumed result
//   avg_data   out  W   rounded block mean
//   min_data   out  W   block minimum
//   max_data   out  W   block maximum
//   overrun    out  1   sticky: a completed result was dropped
//   drop_cnt   out  16  dropped-result count, saturating
module tdc_avg_accum
    import tdc_pkg::*;
#(
    parameter int W          = TDC_SUM_W,
    parameter int LOG2_N_MAX = TDC_LOG2_N_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_data,
    input  logic          in_dval,
    input  logic          en,
    input  logic [3:0]    log2_n,
    input  logic          clr,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [W-1:0]  avg_data,
    output logic [W-1:0]  min_data,
    output logic [W-1:0]  max_data,
    output logic          overrun,
    output logic [15:0]   drop_cnt
);

    localparam int AW = W + LOG2_N_MAX;   // accumulator width
    localparam int CW = LOG2_N_MAX;       // sample counter holds 0..N-1

    tdc_state_e     state_q, state_d;
    logic [3:0]     k_q;
    logic [AW-1:0]  acc_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   min_q, max_q;
    tdc_result_t    res_q;
    logic           out_valid_q;
    logic           overrun_q;
    logic [15:0]    drop_q;

    logic           accept;
    logic           complete;
    logic           can_load;
    logic [AW-1:0]  acc_sum;
    logic [W-1:0]   min_new, max_new;
    logic [CW:0]    n_full;
    logic [CW-1:0]  n_last;
    logic [W-1:0]   avg_new;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en)  state_d = ST_ACCUM;
            ST_ACCUM: if (!en) state_d = ST_IDLE;
            default:           state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sample path. A sample counts only while enabled in ACCUM; en falling
    // with the last sample discards the block.
    // ------------------------------------------------------------------
    always_comb begin
        accept   = (state_q == ST_ACCUM) && en && in_dval;
        acc_sum  = acc_q + AW'(in_data);
        // First sample of a block seeds both extremes.
        min_new  = ((cnt_q == '0) || (in_data < min_q)) ? in_data : min_q;
        max_new  = ((cnt_q == '0) || (in_data > max_q)) ? in_data : max_q;
        n_full   = (CW+1)'(1) << k_q;
        n_last   = CW'(n_full - (CW+1)'(1));
        complete = accept && (cnt_q == n_last);
        can_load = !out_valid_q || out_ready;
    end

    // The final sample is folded in combinationally so the result is
    // registered on the same edge that captures it.
    tdc_round_shift #(
        .W  (W),
        .AW (AW)
    ) u_round (
        .acc (acc_sum),
        .k   (k_q),
        .avg (avg_new)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
        end else if (clr) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && en) begin
                k_q   <= clamp_k(log2_n, LOG2_N_MAX);
                acc_q <= '0;
                cnt_q <= '0;
                min_q <= '0;
                max_q <= '0;
            end else if ((state_q == ST_ACCUM) && !en) begin
                acc_q <= '0;
                cnt_q <= '0;
                min_q <= '0;
                max_q <= '0;
            end else if (complete) begin
                // Next block starts on the very next sample with the same k.
                acc_q <= '0;
                cnt_q <= '0;
                min_q <= '0;
                max_q <= '0;
            end else if (accept) begin
                acc_q <= acc_sum;
                cnt_q <= cnt_q + CW'(1);
                min_q <= min_new;
                max_q <= max_new;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result register and overrun accounting
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            drop_q      <= '0;
        end else if (clr) begin
            res_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            drop_q      <= '0;
        end else if (complete) begin
            if (can_load) begin
                // Also covers a completion coinciding with a transfer:
                // out_valid simply stays high with the fresh result.
                res_q.avg   <= TDC_SUM_W'(avg_new);
                res_q.min   <= TDC_SUM_W'(min_new);
                res_q.max   <= TDC_SUM_W'(max_new);
                out_valid_q <= 1'b1;
            end else begin
                overrun_q <= 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_q <= drop_q + 16'd1;
                end
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign avg_data  = W'(res_q.avg);
    assign min_data  = W'(res_q.min);
    assign max_data  = W'(res_q.max);
    assign overrun   = overrun_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_tdc_avg_accum.sv
// Directed testbench for tdc_avg_accum. Inputs change on the falling edge,
// the DUT captures on the rising edge, outputs are inspected on the next
// falling edge.
module tb_tdc_avg_accum;

    localparam int W = 37;
    localparam logic [W-1:0] ONES = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_data;
    logic          in_dval;
    logic          en;
    logic [3:0]    log2_n;
    logic          clr;
    logic          out_ready;
    logic          out_valid;
    logic [W-1:0]  avg_data;
    logic [W-1:0]  min_data;
    logic [W-1:0]  max_data;
    logic          overrun;
    logic [15:0]   drop_cnt;

    int checks = 0;
    int errors = 0;

    tdc_avg_accum #(.W(W), .LOG2_N_MAX(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_dval   (in_dval),
        .en        (en),
        .log2_n    (log2_n),
        .clr       (clr),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .avg_data  (avg_data),
        .min_data  (min_data),
        .max_data  (max_data),
        .overrun   (overrun),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus primitives ----------------
    task automatic start(input logic [3:0] k);
        @(negedge clk);
        en     = 1'b1;
        log2_n = k;
    endtask

    task automatic stop();
        @(negedge clk);
        en      = 1'b0;
        in_dval = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] v);
        @(negedge clk);
        in_data = v;
        in_dval = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_dval = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, overrun} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got valid=%0b overrun=%0b expected 0 0", out_valid, overrun);
        end
        checks++;
        if ({avg_data, min_data, max_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: got avg=%0d min=%0d max=%0d expected 0 0 0", avg_data, min_data, max_data);
        end
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_drop: got %0d expected 0", drop_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        out_ready = 1'b0;
        start(4'd2);
        send(37'd100); send(37'd200); send(37'd300); idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid: got %0b expected 0", out_valid);
        end
        send(37'd401); idle();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_valid: got %0b expected 1", out_valid);
        end
        checks++;
        if ({avg_data, min_data, max_data} !== {37'd250, 37'd100, 37'd401}) begin
            errors++;
            $display("FAIL basic_result: got avg=%0d min=%0d max=%0d expected 250 100 401", avg_data, min_data, max_data);
        end
        @(negedge clk);
        checks++;
        if (avg_data !== 37'd250) begin
            errors++;
            $display("FAIL basic_hold: got %0d expected 250", avg_data);
        end
        drain();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: got %0b expected 0", out_valid);
        end
    endtask

    task automatic test_rounding();
        // Still in ACCUM with k=2 from test_basic.
        send(37'd2); send(37'd2); send(37'd2); send(37'd4); idle();
        checks++;
        if ({out_valid, avg_data, min_data, max_data} !== {1'b1, 37'd3, 37'd2, 37'd4}) begin
            errors++;
            $display("FAIL round_up: got valid=%0b avg=%0d min=%0d max=%0d expected 1 3 2 4", out_valid, avg_data, min_data, max_data);
        end
        drain();
        send(37'd1); send(37'd1); send(37'd1); send(37'd2); idle();
        checks++;
        if ({out_valid, avg_data, min_data, max_data} !== {1'b1, 37'd1, 37'd1, 37'd2}) begin
            errors++;
            $display("FAIL round_down: got valid=%0b avg=%0d min=%0d max=%0d expected 1 1 1 2", out_valid, avg_data, min_data, max_data);
        end
        drain();
        stop();
    endtask

    task automatic test_max_width();
        start(4'd8);
        for (int i = 0; i < 255; i++) send(ONES);
        idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wide_early_valid: got %0b expected 0", out_valid);
        end
        send(ONES); idle();
        checks++;
        if ({out_valid, avg_data, min_data, max_data} !== {1'b1, ONES, ONES, ONES}) begin
            errors++;
            $display("FAIL wide_result: got valid=%0b avg=%0h min=%0h max=%0h expected 1 %0h %0h %0h", out_valid, avg_data, min_data, max_data, ONES, ONES, ONES);
        end
        drain();
        stop();
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        start(4'd1);
        send(37'd10); send(37'd20); idle();
        checks++;
        if ({out_valid, avg_data, overrun} !== {1'b1, 37'd15, 1'b0}) begin
            errors++;
            $display("FAIL ovr_first: got valid=%0b avg=%0d overrun=%0b expected 1 15 0", out_valid, avg_data, overrun);
        end
        send(37'd30); send(37'd40); idle();
        checks++;
        if ({out_valid, avg_data, min_data, max_data} !== {1'b1, 37'd15, 37'd10, 37'd20}) begin
            errors++;
            $display("FAIL ovr_hold: got valid=%0b avg=%0d min=%0d max=%0d expected 1 15 10 20", out_valid, avg_data, min_data, max_data);
        end
        checks++;
        if ({overrun, drop_cnt} !== {1'b1, 16'd1}) begin
            errors++;
            $display("FAIL ovr_flag: got overrun=%0b drop=%0d expected 1 1", overrun, drop_cnt);
        end
        drain();
        checks++;
        if ({out_valid, overrun} !== 2'b01) begin
            errors++;
            $display("FAIL ovr_drain: got valid=%0b overrun=%0b expected 0 1", out_valid, overrun);
        end
        stop();
    endtask

    task automatic test_clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if ({overrun, drop_cnt, out_valid} !== {1'b0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL clr: got overrun=%0b drop=%0d valid=%0b expected 0 0 0", overrun, drop_cnt, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        start(4'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if ({out_valid, avg_data, min_data} !== {1'b1, W'(4 + i), W'(4 + i)}) begin
                    errors++;
                    $display("FAIL b2b_%0d: got valid=%0b avg=%0d min=%0d expected 1 %0d %0d", i, out_valid, avg_data, min_data, 4 + i, 4 + i);
                end
            end
            in_data = W'(5 + i);
            in_dval = 1'b1;
        end
        idle();
        checks++;
        if ({out_valid, avg_data, max_data} !== {1'b1, 37'd7, 37'd7}) begin
            errors++;
            $display("FAIL b2b_last: got valid=%0b avg=%0d max=%0d expected 1 7 7", out_valid, avg_data, max_data);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, overrun, drop_cnt} !== {1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL b2b_end: got valid=%0b overrun=%0b drop=%0d expected 0 0 0", out_valid, overrun, drop_cnt);
        end
        stop();
    endtask

    task automatic test_en_drop();
        out_ready = 1'b1;
        start(4'd2);
        send(37'd1); send(37'd2); send(37'd3);
        // en falls together with the 4th sample: block discarded.
        @(negedge clk);
        in_data = 37'd400;
        in_dval = 1'b1;
        en      = 1'b0;
        idle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL endrop_valid: got %0b expected 0", out_valid);
        end
        start(4'd2);
        send(37'd8); send(37'd8); send(37'd8); send(37'd9);
        @(negedge clk);
        in_dval   = 1'b0;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, avg_data, min_data, max_data} !== {1'b1, 37'd8, 37'd8, 37'd9}) begin
            errors++;
            $display("FAIL endrop_next: got valid=%0b avg=%0d min=%0d max=%0d expected 1 8 8 9", out_valid, avg_data, min_data, max_data);
        end
        drain();
        stop();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        start(4'd2);
        for (int i = 0; i < 8; i++) send(37'd10);
        send(37'd5);
        #2;
        checks++;
        if ({out_valid, overrun, drop_cnt} !== {1'b1, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL arst_pre: got valid=%0b overrun=%0b drop=%0d expected 1 1 1", out_valid, overrun, drop_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, overrun, drop_cnt, avg_data, min_data, max_data} !== '0) begin
            errors++;
            $display("FAIL arst_clear: got valid=%0b overrun=%0b drop=%0d avg=%0d expected all 0", out_valid, overrun, drop_cnt, avg_data);
        end
        @(negedge clk);
        en      = 1'b0;
        in_dval = 1'b0;
        rst     = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        in_data   = '0;
        in_dval   = 1'b0;
        en        = 1'b0;
        log2_n    = '0;
        clr       = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_rounding();
        test_max_width();
        test_overrun();
        test_clear();
        test_back_to_back();
        test_en_drop();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
